// File: rtl/dispensador_pkg.sv
// dispensador_pkg
//   Shared definitions for the beverage dispenser sequencer:
//   - state encoding (also driven out on Etapa for display/debug)
//   - bit positions of the fields inside the Sel selection code
//   - base-drink codes carried in Sel[1:0]
//   - next_stage(): which valve stage follows a finished stage
package dispensador_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    AGUA  = 3'd1,
    BASE  = 3'd2,
    LECHE = 3'd3,
    VAIN  = 3'd4,
    FIN   = 3'd5
  } state_t;

  localparam int SEL_BASE_LO = 0;
  localparam int SEL_BASE_HI = 1;
  localparam int SEL_LECHE   = 2;
  localparam int SEL_VAIN    = 3;

  localparam logic [1:0] BASE_AGUA = 2'b00;
  localparam logic [1:0] BASE_CAFE = 2'b01;
  localparam logic [1:0] BASE_TE   = 2'b10;

  // Stage order is fixed (water, base, milk, vanilla); unselected stages
  // are skipped. Water is always dispensed, so it never appears as a result.
  function automatic state_t next_stage(input state_t cur, input logic [3:0] sel);
    logic has_base;
    state_t nxt;
    has_base = (sel[SEL_BASE_HI:SEL_BASE_LO] == BASE_CAFE) ||
               (sel[SEL_BASE_HI:SEL_BASE_LO] == BASE_TE);
    nxt = FIN;
    case (cur)
      AGUA: begin
        if (has_base)            nxt = BASE;
        else if (sel[SEL_LECHE]) nxt = LECHE;
        else if (sel[SEL_VAIN])  nxt = VAIN;
        else                     nxt = FIN;
      end
      BASE: begin
        if (sel[SEL_LECHE])      nxt = LECHE;
        else if (sel[SEL_VAIN])  nxt = VAIN;
        else                     nxt = FIN;
      end
      LECHE: begin
        if (sel[SEL_VAIN])       nxt = VAIN;
        else                     nxt = FIN;
      end
      default:                   nxt = FIN;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/dispensador_bebida_prescaler.sv
// prescaler_tick
//   Divides the system clock into "second" ticks.
//   Counts 0..TICK_DIV-1 and wraps; tick is high while the count reads
//   TICK_DIV-1. clr holds the count at 0 (used while the sequencer idles so
//   every drink starts on a fresh tick boundary).
// Ports:
//   CLK   in  system clock, rising edge
//   RESET in  synchronous, active-high reset
//   clr   in  synchronous clear
//   tick  out one-cycle pulse every TICK_DIV cycles
module prescaler_tick #(
  parameter int TICK_DIV = 10,
  parameter int CNT_W    = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RESET || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/dispensador_bebida.sv
// dispensador_bebida
//   Accepts a drink selection over a valid/ready handshake and sequences the
//   valves: water, base (coffee/tea), milk, vanilla. Each stage lasts
//   T_x ticks of the internal prescaler (T_x*TICK_DIV clock cycles).
//   Optional build macro: DISP_CANCEL_EN adds input Cancelar, which aborts
//   an active dispense (valves closed, Error pulse, back to IDLE).
// Ports:
//   CLK, RESET        clock and synchronous active-high reset
//   Sel[3:0]          [1:0] base (00 water, 01 coffee, 10 tea, 11 invalid),
//                     [2] milk, [3] vanilla
//   SelValid/SelReady selection handshake (ready only in IDLE)
//   VAgua..VVainilla  valve drives, at most one high
//   Ocupado           not IDLE
//   Listo             one-cycle pulse in FIN
//   Error             one-cycle pulse after invalid code (or cancel)
//   Etapa[2:0]        current state code
//   Cancelar          (DISP_CANCEL_EN only) abort request
//
// state | meaning
// IDLE  | waiting for a selection, SelReady high
// AGUA  | water valve open
// BASE  | coffee or tea valve open
// LECHE | milk valve open
// VAIN  | vanilla valve open
// FIN   | one cycle, Listo high
module dispensador_bebida
  import dispensador_pkg::*;
#(
  parameter int TICK_DIV = 10,
  parameter int T_AGUA   = 3,
  parameter int T_BASE   = 2,
  parameter int T_LECHE  = 2,
  parameter int T_VAIN   = 1,
  parameter int CNT_W    = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] Sel,
  input  logic       SelValid,
`ifdef DISP_CANCEL_EN
  input  logic       Cancelar,
`endif
  output logic       SelReady,
  output logic       VAgua,
  output logic       VCafe,
  output logic       VTe,
  output logic       VLeche,
  output logic       VVainilla,
  output logic       Ocupado,
  output logic       Listo,
  output logic       Error,
  output logic [2:0] Etapa
);

  state_t           state_q, state_d;
  logic [3:0]       sel_q;
  logic             accept;
  logic             err_d;
  logic             tick;
  logic [CNT_W-1:0] stage_cnt;
  logic [CNT_W-1:0] stage_last;
  logic             stage_done;
  logic             cancel;

  // Prescaler is held in reset while idle, so the first tick of a drink
  // lands TICK_DIV cycles after the accept edge.
  prescaler_tick #(
    .TICK_DIV(TICK_DIV),
    .CNT_W   (CNT_W)
  ) u_prescaler (
    .CLK  (CLK),
    .RESET(RESET),
    .clr  (state_q == IDLE),
    .tick (tick)
  );

`ifdef DISP_CANCEL_EN
  assign cancel = Cancelar && (state_q != IDLE);
`else
  assign cancel = 1'b0;
`endif

  always_comb begin
    stage_last = '0;
    case (state_q)
      AGUA:    stage_last = CNT_W'(T_AGUA - 1);
      BASE:    stage_last = CNT_W'(T_BASE - 1);
      LECHE:   stage_last = CNT_W'(T_LECHE - 1);
      VAIN:    stage_last = CNT_W'(T_VAIN - 1);
      default: stage_last = '0;
    endcase
  end

  assign stage_done = tick && (stage_cnt == stage_last);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (SelValid) begin
          accept = 1'b1;
          if (Sel[SEL_BASE_HI:SEL_BASE_LO] == 2'b11) err_d = 1'b1;
          else                                       state_d = AGUA;
        end
      end
      AGUA, BASE, LECHE, VAIN: begin
        if (stage_done) state_d = next_stage(state_q, sel_q);
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (cancel) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) sel_q <= Sel;
    end
  end

  // Stage counter restarts on every state change, so each stage counts
  // its own ticks from zero.
  always_ff @(posedge CLK) begin
    if (RESET || (state_q == IDLE) || (state_q == FIN) || (state_d != state_q)) begin
      stage_cnt <= '0;
    end else if (tick) begin
      stage_cnt <= stage_cnt + CNT_W'(1);
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      SelReady  <= 1'b1;
      VAgua     <= 1'b0;
      VCafe     <= 1'b0;
      VTe       <= 1'b0;
      VLeche    <= 1'b0;
      VVainilla <= 1'b0;
      Ocupado   <= 1'b0;
      Listo     <= 1'b0;
      Error     <= 1'b0;
    end else begin
      SelReady  <= (state_d == IDLE);
      VAgua     <= (state_d == AGUA);
      VCafe     <= (state_d == BASE) && (sel_q[SEL_BASE_HI:SEL_BASE_LO] == BASE_CAFE);
      VTe       <= (state_d == BASE) && (sel_q[SEL_BASE_HI:SEL_BASE_LO] == BASE_TE);
      VLeche    <= (state_d == LECHE);
      VVainilla <= (state_d == VAIN);
      Ocupado   <= (state_d != IDLE);
      Listo     <= (state_d == FIN);
      Error     <= err_d;
    end
  end

  assign Etapa = state_q;

endmodule

// File: tb/tb_dispensador_bebida.sv
module tb_dispensador_bebida;

  localparam int TD = 10;
  localparam int TA = 3;
  localparam int TB = 2;
  localparam int TL = 2;
  localparam int TV = 1;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] Sel = 4'd0;
  logic       SelValid = 1'b0;
`ifdef DISP_CANCEL_EN
  logic       Cancelar = 1'b0;
`endif
  logic       SelReady, VAgua, VCafe, VTe, VLeche, VVainilla, Ocupado, Listo, Error;
  logic [2:0] Etapa;

  dispensador_bebida dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .Sel      (Sel),
    .SelValid (SelValid),
`ifdef DISP_CANCEL_EN
    .Cancelar (Cancelar),
`endif
    .SelReady (SelReady),
    .VAgua    (VAgua),
    .VCafe    (VCafe),
    .VTe      (VTe),
    .VLeche   (VLeche),
    .VVainilla(VVainilla),
    .Ocupado  (Ocupado),
    .Listo    (Listo),
    .Error    (Error),
    .Etapa    (Etapa)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  // Reference model: a drink is a list of (valve, length) segments; the
  // outputs follow from the number of edges elapsed since the accept.
  // valve ids: 0 water, 1 coffee, 2 tea, 3 milk, 4 vanilla
  bit m_busy = 0;
  bit m_err = 0;
  bit m_ready;
  int m_e = 0;
  int m_total = 0;
  int m_nseg = 0;
  int m_id[4];
  int m_len[4];

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    m_ready = !m_busy;
    m_err = 0;
    if (RESET) begin
      m_busy = 0;
      m_e = 0;
    end else begin
`ifdef DISP_CANCEL_EN
      if (Cancelar && m_busy) begin
        m_busy = 0;
        m_err = 1;
      end else
`endif
      if (m_busy) begin
        m_e++;
        if (m_e == m_total + 2) m_busy = 0;
      end
      if (m_ready && SelValid) begin
        if (Sel[1:0] == 2'b11) begin
          m_err = 1;
        end else begin
          m_nseg = 0;
          m_id[m_nseg] = 0; m_len[m_nseg] = TA * TD; m_nseg++;
          if (Sel[1:0] == 2'b01) begin m_id[m_nseg] = 1; m_len[m_nseg] = TB * TD; m_nseg++; end
          if (Sel[1:0] == 2'b10) begin m_id[m_nseg] = 2; m_len[m_nseg] = TB * TD; m_nseg++; end
          if (Sel[2]) begin m_id[m_nseg] = 3; m_len[m_nseg] = TL * TD; m_nseg++; end
          if (Sel[3]) begin m_id[m_nseg] = 4; m_len[m_nseg] = TV * TD; m_nseg++; end
          m_total = 0;
          for (int i = 0; i < m_nseg; i++) m_total += m_len[i];
          m_busy = 1;
          m_e = 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  int         c_id, c_acc, c_etapa;
  bit         c_listo;
  logic [11:0] c_exp, c_got;

  always @(negedge CLK) begin
    if (cyc > 0) begin
      c_id = -1;
      c_acc = 0;
      c_etapa = 0;
      c_listo = 0;
      if (m_busy) begin
        if (m_e <= m_total) begin
          for (int i = 0; i < m_nseg; i++) begin
            if (m_e > c_acc && m_e <= c_acc + m_len[i]) c_id = m_id[i];
            c_acc += m_len[i];
          end
          c_etapa = (c_id == 0) ? 1 : (c_id <= 2) ? 2 : (c_id == 3) ? 3 : 4;
        end else begin
          c_etapa = 5;
          c_listo = 1;
        end
      end
      c_exp = {!m_busy, c_id == 0, c_id == 1, c_id == 2, c_id == 3, c_id == 4,
               m_busy, c_listo, m_err, 3'(c_etapa)};
      c_got = {SelReady, VAgua, VCafe, VTe, VLeche, VVainilla, Ocupado, Listo, Error, Etapa};
      checks++;
      if (c_got !== c_exp) begin
        errors++;
        $display("FAIL trace cyc=%0d got=%b want=%b (rdy,agua,cafe,te,leche,vain,ocup,listo,err,etapa)",
                 cyc, c_got, c_exp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (SelReady !== 1'b1 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 300) chk("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  // Called at a negedge; returns at the negedge inside cycle n (the period
  // that follows edge n-1).
  task automatic wait_cycle(input int n);
    int g = 0;
    while (cyc < n - 1 && g < 1000) begin
      @(negedge CLK);
      g++;
    end
    if (g >= 1000) chk("wait_cycle_timeout", 32'd0, 32'd1);
  endtask

  task automatic accept(input logic [3:0] s, output int k);
    wait_idle();
    Sel = s;
    SelValid = 1'b1;
    @(posedge CLK);
    #1 k = cyc;
    @(negedge CLK);
    SelValid = 1'b0;
  endtask

  initial begin
    int k;
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_ready", 32'(SelReady), 32'd1);
    chk("reset_valves", 32'({VAgua, VCafe, VTe, VLeche, VVainilla}), 32'd0);
    chk("reset_etapa", 32'(Etapa), 32'd0);
    chk("reset_ocupado", 32'(Ocupado), 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // coffee + milk
    accept(4'b0101, k);
    chk("cafe_leche_agua_first", 32'(VAgua), 32'd1);
    wait_cycle(k + 30); chk("cafe_leche_agua_last", 32'(VAgua), 32'd1);
    wait_cycle(k + 31); chk("cafe_leche_cafe_first", 32'({VAgua, VCafe}), 32'b01);
    wait_cycle(k + 50); chk("cafe_leche_cafe_last", 32'(VCafe), 32'd1);
    wait_cycle(k + 51); chk("cafe_leche_leche_first", 32'({VCafe, VLeche}), 32'b01);
    wait_cycle(k + 70); chk("cafe_leche_leche_last", 32'(VLeche), 32'd1);
    wait_cycle(k + 71); chk("cafe_leche_listo", 32'({Listo, VLeche, SelReady}), 32'b100);
    wait_cycle(k + 72); chk("cafe_leche_ready", 32'({SelReady, Listo}), 32'b10);

    // tea + vanilla
    accept(4'b1010, k);
    wait_cycle(k + 31); chk("te_vain_te_first", 32'(VTe), 32'd1);
    wait_cycle(k + 50); chk("te_vain_te_last", 32'(VTe), 32'd1);
    wait_cycle(k + 51); chk("te_vain_vain_first", 32'({VTe, VVainilla, VLeche}), 32'b010);
    wait_cycle(k + 60); chk("te_vain_vain_last", 32'(VVainilla), 32'd1);
    wait_cycle(k + 61); chk("te_vain_listo", 32'({Listo, VVainilla, Etapa}), 32'b10101);

    // water only, with a different selection held valid while busy
    accept(4'b0000, k);
    Sel = 4'b0101;
    SelValid = 1'b1;
    wait_cycle(k + 30); chk("agua_last", 32'({VAgua, Etapa}), 32'b1001);
    wait_cycle(k + 31); chk("agua_listo", 32'({Listo, VAgua}), 32'b10);
    wait_cycle(k + 32); chk("held_ready", 32'(SelReady), 32'd1);
    wait_cycle(k + 33); chk("held_accepted", 32'({VAgua, Ocupado}), 32'b11);
    SelValid = 1'b0;

    // invalid code
    accept(4'b0011, k);
    chk("invalid_error", 32'({Error, SelReady, Ocupado}), 32'b110);
    chk("invalid_valves", 32'({VAgua, VCafe, VTe, VLeche, VVainilla}), 32'd0);
    wait_cycle(k + 2); chk("invalid_error_clears", 32'({Error, SelReady}), 32'b01);

    // reset during BASE
    accept(4'b0101, k);
    wait_cycle(k + 35);
    chk("pre_reset_cafe", 32'(VCafe), 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    chk("midreset_valves", 32'({VAgua, VCafe, VTe, VLeche, VVainilla, Etapa}), 32'd0);
    chk("midreset_ready", 32'(SelReady), 32'd1);
    RESET = 1'b0;
    accept(4'b0001, k);
    wait_cycle(k + 31); chk("after_reset_cafe_first", 32'({VAgua, VCafe}), 32'b01);
    wait_cycle(k + 50); chk("after_reset_cafe_last", 32'(VCafe), 32'd1);
    wait_cycle(k + 51); chk("after_reset_listo", 32'({Listo, VCafe}), 32'b10);

`ifdef DISP_CANCEL_EN
    accept(4'b0101, k);
    wait_cycle(k + 55);
    Cancelar = 1'b1;
    @(negedge CLK);
    Cancelar = 1'b0;
    chk("cancel_state", 32'({Error, Listo, VLeche, Etapa}), 32'b100000);
`endif

    // randomized traffic
    wait_idle();
    repeat (3000) begin
      @(negedge CLK);
      SelValid = ($urandom_range(0, 3) == 0);
      Sel = 4'($urandom_range(0, 15));
      RESET = ($urandom_range(0, 399) == 0);
`ifdef DISP_CANCEL_EN
      Cancelar = ($urandom_range(0, 199) == 0);
`endif
    end
    @(negedge CLK);
    RESET = 1'b0;
    SelValid = 1'b0;
`ifdef DISP_CANCEL_EN
    Cancelar = 1'b0;
`endif
    repeat (100) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dispensador_bebida.md
Name: dispensador_bebida

Overview:
- Downstream stage of the beverage selector FSM.
- Accepts a finished drink selection through a valid/ready handshake and sequences the dispensing valves: water, then base (coffee/tea), then milk, then vanilla.
- Each stage is held for a programmable number of "seconds" ticks, generated by an internal prescaler on the single system clock. This replaces the separate timer clock used in the selector's bench.

Parameters:
- TICK_DIV, 10: CLK cycles per second-tick (matches the CLK:CLK2 ratio of the selector bench).
- T_AGUA, 3: ticks for the water stage.
- T_BASE, 2: ticks for the coffee/tea stage.
- T_LECHE, 2: ticks for the milk stage.
- T_VAIN, 1: ticks for the vanilla stage.
- CNT_W, 8: width of the prescaler and stage counters; every T_* and TICK_DIV must fit in it and be ≥1.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- Sel  in  4  selection code. [1:0] base: 00 water-only, 01 coffee, 10 tea, 11 invalid. [2] milk. [3] vanilla.
- SelValid  in  1  Sel is valid.
- SelReady  out  1  block can accept a selection; high only in IDLE.
- VAgua, VCafe, VTe, VLeche, VVainilla  out  1 each  valve drives; at most one high at a time.
- Ocupado  out  1  dispensing in progress (any state other than IDLE).
- Listo  out  1  one-cycle pulse when a drink completes.
- Error  out  1  one-cycle pulse when an invalid code is accepted.
- Etapa  out  3  current state code, for debug and display.

Behaviour:
- Interface: the clock is CLK; the reset is RESET, synchronous and active-high. All outputs are registered.
- Reset values: state IDLE, all valves 0, Ocupado 0, Listo 0, Error 0, SelReady 1, Etapa 0, counters 0.
- A RESET asserted mid-dispense returns the block to IDLE on the next edge with all valves closed; the latched selection is discarded.
- States and Etapa codes: IDLE=0, AGUA=1, BASE=2, LECHE=3, VAIN=4, FIN=5.
- Accept: on an edge with SelValid & SelReady, Sel is latched and the prescaler and stage counter are cleared.
  - If Sel[1:0]==11: Error=1 for the next cycle and the block stays in IDLE.
  - Otherwise: next state is AGUA.
- SelValid while not ready is ignored; the source must hold the selection until it is accepted.
- Tick generation: the prescaler counts 0..TICK_DIV-1 and wraps; tick=1 when it reads TICK_DIV-1.
- Stage timing:
  - The stage counter increments on tick.
  - A stage exits on the edge where tick is high and the stage counter == T_x-1; the stage counter then clears.
  - Each active stage therefore lasts exactly T_x*TICK_DIV cycles.
- Transitions:
  - AGUA → BASE if the base is coffee or tea, else → LECHE/VAIN/FIN.
  - BASE → LECHE if milk is selected, else → VAIN if vanilla is selected, else → FIN.
  - LECHE → VAIN if vanilla is selected, else → FIN.
  - VAIN → FIN.
  - FIN → IDLE after exactly 1 cycle, with Listo=1 during FIN.
- Valve outputs by state:
  - AGUA: VAgua.
  - BASE: VCafe or VTe, per the latched base.
  - LECHE: VLeche.
  - VAIN: VVainilla.
  - No valve is high in IDLE or FIN.
- Latency with defaults: an accept at edge k drives VAgua high for cycles k+1..k+30. Listo timing depends on the stages selected; see Test Plan for worked values.
- SelReady returns to 1 the cycle after FIN.

Optional Feature:
- Macro DISP_CANCEL_EN.
- When defined:
  - Adds input Cancelar (1 bit).
  - If Cancelar=1 in any active state, the next edge closes all valves, goes to IDLE and pulses Listo=0 / Error=1 for one cycle.
  - Cancelar in IDLE is ignored.
- When undefined: the port is absent and dispensing always runs to completion.

Decomposition:
- Shared package dispensador_pkg contains:
  - the state encoding constants (IDLE..FIN);
  - the Sel field positions;
  - the base code constants BASE_AGUA=2'b00, BASE_CAFE=2'b01, BASE_TE=2'b10.
- One sub-module: prescaler_tick (parameter TICK_DIV; ports CLK, RESET, clr, tick).

Test Plan:
- Reset: assert RESET for 2 cycles → all valves 0, SelReady=1, Etapa=0.
- Sel=4'b0101 (coffee + milk) accepted at cycle k:
  - VAgua for cycles k+1..k+30, VCafe for k+31..k+50, VLeche for k+51..k+70.
  - Listo=1 at k+71; SelReady=1 at k+72.
- Sel=4'b1010 (tea + vanilla):
  - VTe for 20 cycles, then VVainilla for 10 cycles.
  - Listo 1 cycle after VVainilla falls; VLeche is never asserted.
- Sel=4'b0000 (water only): VAgua for 30 cycles, then Listo. Sel=4'b0011 → Error pulse, no valve asserted, SelReady stays 1.
- RESET asserted for 1 cycle during the BASE stage → all valves 0 on the next edge. A new selection is then accepted normally with exact stage durations.
- SelValid held high during Ocupado with a different Sel → the held value is ignored until IDLE. With DISP_CANCEL_EN, Cancelar during LECHE → valves off, Error pulse, IDLE.
